// File: rtl/vexriscv_tdp_ram_if.sv
// rtl/vexriscv_tdp_ram_if.sv - request/response channel bundle for one RAM port
interface vexriscv_tdp_ram_if #(
  parameter int DATA_W = 32,
  parameter int BYTE_W = 8,
  parameter int AW     = 13
) ();
  localparam int NB = DATA_W / BYTE_W;

  logic              req_valid;
  logic              req_ready;
  logic              we;
  logic [NB-1:0]     be;
  logic [AW-1:0]     addr;
  logic [DATA_W-1:0] wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req_valid, we, be, addr, wdata, rsp_ready,
    input  req_ready, rsp_valid, rdata
  );

  modport slave (
    input  req_valid, we, be, addr, wdata, rsp_ready,
    output req_ready, rsp_valid, rdata
  );
endinterface

// File: rtl/vexriscv_tdp_ram.sv
// rtl/vexriscv_tdp_ram.sv - true dual-port single-clock RAM with valid/ready ports
module vexriscv_tdp_ram #(
  parameter int    DATA_W     = 32,
  parameter int    BYTE_W     = 8,
  parameter int    DEPTH      = 8192,
  parameter int    OUT_REG    = 0,
  parameter string WRITE_MODE = "NO_CHANGE",
  parameter string INIT_FILE  = ""
) (
  input logic               clk,
  input logic               reset,
  vexriscv_tdp_ram_if.slave a,
  vexriscv_tdp_ram_if.slave b
);
  localparam int NB = DATA_W / BYTE_W;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam bit MODE_RF = (WRITE_MODE == "READ_FIRST");
  localparam bit MODE_WF = (WRITE_MODE == "WRITE_FIRST");

  logic [DATA_W-1:0] mem [DEPTH];

  // Port-indexed views: index 0 is port A (instruction), 1 is port B (data).
  logic [1:0]        req_valid;
  logic [1:0]        we;
  logic [1:0]        rsp_ready;
  logic [NB-1:0]     be       [2];
  logic [AW-1:0]     addr     [2];
  logic [DATA_W-1:0] wdata    [2];

  logic [1:0]        req_ready;
  logic [1:0]        accept;
  logic [1:0]        in_range;
  logic [1:0]        s2_load;
  logic [AW-1:0]     rd_idx   [2];
  logic [DATA_W-1:0] old_word [2];
  logic [DATA_W-1:0] merged   [2];

  logic [1:0]        s1_v_d, s1_v_q;
  logic [1:0]        s2_v_d, s2_v_q;
  logic [DATA_W-1:0] s1_data_d [2];
  logic [DATA_W-1:0] s1_data_q [2];
  logic [DATA_W-1:0] s2_data_d [2];
  logic [DATA_W-1:0] s2_data_q [2];

  assign req_valid = {b.req_valid, a.req_valid};
  assign we        = {b.we, a.we};
  assign rsp_ready = {b.rsp_ready, a.rsp_ready};
  assign be[0]     = a.be;
  assign be[1]     = b.be;
  assign addr[0]   = a.addr;
  assign addr[1]   = b.addr;
  assign wdata[0]  = a.wdata;
  assign wdata[1]  = b.wdata;

  assign a.req_ready = req_ready[0];
  assign b.req_ready = req_ready[1];
  assign a.rsp_valid = (OUT_REG != 0) ? s2_v_q[0]    : s1_v_q[0];
  assign b.rsp_valid = (OUT_REG != 0) ? s2_v_q[1]    : s1_v_q[1];
  assign a.rdata     = (OUT_REG != 0) ? s2_data_q[0] : s1_data_q[0];
  assign b.rdata     = (OUT_REG != 0) ? s2_data_q[1] : s1_data_q[1];

  // Power-up contents: zeros.
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
  end

  // Per-port handshake, old-word read, byte merge and pipeline next state.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      in_range[p]  = (32'(addr[p]) < DEPTH);
      rd_idx[p]    = in_range[p] ? addr[p] : '0;
      old_word[p]  = in_range[p] ? mem[rd_idx[p]] : '0;
      merged[p]    = old_word[p];
      for (int i = 0; i < NB; i++) begin
        if (be[p][i]) merged[p][i*BYTE_W +: BYTE_W] = wdata[p][i*BYTE_W +: BYTE_W];
      end

      s2_load[p]   = !s2_v_q[p] || rsp_ready[p];
      req_ready[p] = !reset && (!s1_v_q[p] || ((OUT_REG != 0) ? s2_load[p] : rsp_ready[p]));
      accept[p]    = req_valid[p] && req_ready[p];

      s1_v_d[p]    = s1_v_q[p];
      s1_data_d[p] = s1_data_q[p];
      s2_v_d[p]    = 1'b0;
      s2_data_d[p] = '0;

      if (OUT_REG != 0) begin
        s1_v_d[p]    = accept[p] || (s1_v_q[p] && !s2_load[p]);
        s2_v_d[p]    = s2_load[p] ? s1_v_q[p] : s2_v_q[p];
        s2_data_d[p] = (s2_load[p] && s1_v_q[p]) ? s1_data_q[p] : s2_data_q[p];
      end else begin
        s1_v_d[p]    = accept[p] || (s1_v_q[p] && !rsp_ready[p]);
      end

      // The data register only moves on accept; NO_CHANGE writes keep it.
      if (accept[p]) begin
        if (!we[p])           s1_data_d[p] = old_word[p];
        else if (!in_range[p]) s1_data_d[p] = '0;
        else if (MODE_RF)      s1_data_d[p] = old_word[p];
        else if (MODE_WF)      s1_data_d[p] = merged[p];
        else                   s1_data_d[p] = s1_data_q[p];
      end

      if (reset) begin
        s1_v_d[p]    = 1'b0;
        s2_v_d[p]    = 1'b0;
        s1_data_d[p] = '0;
        s2_data_d[p] = '0;
      end
    end
  end

  // Pipeline registers.
  always_ff @(posedge clk) begin
    s1_v_q    <= s1_v_d;
    s2_v_q    <= s2_v_d;
    s1_data_q <= s1_data_d;
    s2_data_q <= s2_data_d;
  end

  // Byte-lane writes; B is applied first so A wins any lane both ports enable.
  always_ff @(posedge clk) begin
    for (int p = 1; p >= 0; p--) begin
      if (accept[p] && we[p] && in_range[p]) begin
        for (int i = 0; i < NB; i++) begin
          if (be[p][i]) mem[addr[p]][i*BYTE_W +: BYTE_W] <= wdata[p][i*BYTE_W +: BYTE_W];
        end
      end
    end
  end
endmodule

// File: tb/tb_vexriscv_tdp_ram.sv
// tb/tb_vexriscv_tdp_ram.sv - scoreboard bench over four RAM configurations
module tb_vexriscv_tdp_ram;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // DUT 0: D16 WRITE_FIRST, 1: D16 READ_FIRST, 2: D16 OUT_REG NO_CHANGE, 3: D12 NO_CHANGE
  logic [1:0]  sel;
  logic        a_req_valid, a_we, a_rsp_ready;
  logic [3:0]  a_be, a_addr;
  logic [31:0] a_wdata;
  logic        b_req_valid, b_we, b_rsp_ready;
  logic [3:0]  b_be, b_addr;
  logic [31:0] b_wdata;

  logic [3:0]  a_ready_v, a_valid_v, b_ready_v, b_valid_v;
  logic [31:0] a_rdata_v [4];
  logic [31:0] b_rdata_v [4];
  logic        a_req_ready, a_rsp_valid, b_req_ready, b_rsp_valid;
  logic [31:0] a_rdata, b_rdata;

  for (genvar k = 0; k < 4; k++) begin : g_dut
    localparam string WM = (k == 0) ? "WRITE_FIRST" : ((k == 1) ? "READ_FIRST" : "NO_CHANGE");
    vexriscv_tdp_ram_if #(.DATA_W(32), .BYTE_W(8), .AW(4)) ia ();
    vexriscv_tdp_ram_if #(.DATA_W(32), .BYTE_W(8), .AW(4)) ib ();

    assign ia.req_valid = a_req_valid && (sel == 2'(k));
    assign ia.we        = a_we;
    assign ia.be        = a_be;
    assign ia.addr      = a_addr;
    assign ia.wdata     = a_wdata;
    assign ia.rsp_ready = a_rsp_ready;
    assign ib.req_valid = b_req_valid && (sel == 2'(k));
    assign ib.we        = b_we;
    assign ib.be        = b_be;
    assign ib.addr      = b_addr;
    assign ib.wdata     = b_wdata;
    assign ib.rsp_ready = b_rsp_ready;

    assign a_ready_v[k] = ia.req_ready;
    assign a_valid_v[k] = ia.rsp_valid;
    assign a_rdata_v[k] = ia.rdata;
    assign b_ready_v[k] = ib.req_ready;
    assign b_valid_v[k] = ib.rsp_valid;
    assign b_rdata_v[k] = ib.rdata;

    vexriscv_tdp_ram #(
      .DATA_W(32), .BYTE_W(8), .DEPTH((k == 3) ? 12 : 16),
      .OUT_REG((k == 2) ? 1 : 0), .WRITE_MODE(WM), .INIT_FILE("")
    ) u_dut (
      .clk(clk), .reset(reset), .a(ia), .b(ib)
    );
  end

  always_comb begin
    a_req_ready = a_ready_v[sel];
    a_rsp_valid = a_valid_v[sel];
    a_rdata     = a_rdata_v[sel];
    b_req_ready = b_ready_v[sel];
    b_rsp_valid = b_valid_v[sel];
    b_rdata     = b_rdata_v[sel];
  end

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_a [$];
  logic [31:0] exp_b [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got timeout/extra expected handshake", name);
  endtask

  // Single-port request; the expected response is queued on the accept edge.
  task automatic issue(input bit port, input bit we, input logic [3:0] be, input logic [3:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp);
    int t;
    bit ok;
    if (!port) begin
      a_req_valid = 1'b1; a_we = we; a_be = be; a_addr = addr; a_wdata = wdata;
    end else begin
      b_req_valid = 1'b1; b_we = we; b_be = be; b_addr = addr; b_wdata = wdata;
    end
    t = 0;
    ok = 1'b0;
    while (!ok && t < 50) begin
      @(negedge clk);
      ok = port ? b_req_ready : a_req_ready;
      t++;
    end
    if (ok) begin
      if (!port) exp_a.push_back(exp);
      else       exp_b.push_back(exp);
    end else flag("issue_timeout");
    @(posedge clk);
    #1;
    if (!port) a_req_valid = 1'b0;
    else       b_req_valid = 1'b0;
  endtask

  // Both ports present in the same cycle.
  task automatic dual(input bit awe, input logic [3:0] abe, input logic [3:0] aaddr,
                      input logic [31:0] awd, input logic [31:0] aexp,
                      input bit bwe, input logic [3:0] bbe, input logic [3:0] baddr,
                      input logic [31:0] bwd, input logic [31:0] bexp);
    int t;
    bit ok;
    a_req_valid = 1'b1; a_we = awe; a_be = abe; a_addr = aaddr; a_wdata = awd;
    b_req_valid = 1'b1; b_we = bwe; b_be = bbe; b_addr = baddr; b_wdata = bwd;
    t = 0;
    ok = 1'b0;
    while (!ok && t < 50) begin
      @(negedge clk);
      ok = a_req_ready && b_req_ready;
      t++;
    end
    if (ok) begin
      exp_a.push_back(aexp);
      exp_b.push_back(bexp);
    end else flag("dual_timeout");
    @(posedge clk);
    #1;
    a_req_valid = 1'b0;
    b_req_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_a.size() != 0 || exp_b.size() != 0) && t < 100) begin
      @(posedge clk);
      t++;
    end
    if (exp_a.size() != 0 || exp_b.size() != 0) begin
      flag("drain_timeout");
      exp_a.delete();
      exp_b.delete();
    end
    @(posedge clk);
    #1;
  endtask

  // Response monitor: scoreboard pops and stall-stability checks.
  logic        a_stall, b_stall;
  logic [31:0] a_hold, b_hold;
  initial begin
    a_stall = 1'b0;
    b_stall = 1'b0;
    a_hold  = '0;
    b_hold  = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        a_stall = 1'b0;
        b_stall = 1'b0;
      end else begin
        if (a_stall) begin
          check("a_stall_valid", 32'(a_rsp_valid), 32'd1);
          check("a_stall_rdata", a_rdata, a_hold);
        end
        if (b_stall) begin
          check("b_stall_valid", 32'(b_rsp_valid), 32'd1);
          check("b_stall_rdata", b_rdata, b_hold);
        end
        if (a_rsp_valid && a_rsp_ready) begin
          if (exp_a.size() == 0) flag("a_extra_beat");
          else check("a_rdata", a_rdata, exp_a.pop_front());
        end
        if (b_rsp_valid && b_rsp_ready) begin
          if (exp_b.size() == 0) flag("b_extra_beat");
          else check("b_rdata", b_rdata, exp_b.pop_front());
        end
        a_stall = a_rsp_valid && !a_rsp_ready;
        b_stall = b_rsp_valid && !b_rsp_ready;
        a_hold  = a_rdata;
        b_hold  = b_rdata;
      end
    end
  end

  typedef struct {
    logic [1:0]  dut;
    bit          port;
    bit          we;
    logic [3:0]  be;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [$];

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    bit bp_done;
    int idx;

    vecs.push_back(vec_t'{2'd0, 1'b0, 1'b0, 4'h0, 4'd3,  32'h0,        32'h00000000});
    vecs.push_back(vec_t'{2'd0, 1'b0, 1'b1, 4'hF, 4'd3,  32'hDEADBEEF, 32'hDEADBEEF});
    vecs.push_back(vec_t'{2'd0, 1'b0, 1'b0, 4'h0, 4'd3,  32'h0,        32'hDEADBEEF});
    vecs.push_back(vec_t'{2'd0, 1'b0, 1'b1, 4'hF, 4'd4,  32'hAABBCCDD, 32'hAABBCCDD});
    vecs.push_back(vec_t'{2'd0, 1'b0, 1'b1, 4'h5, 4'd4,  32'h11223344, 32'hAA22CC44});
    vecs.push_back(vec_t'{2'd0, 1'b1, 1'b0, 4'h0, 4'd4,  32'h0,        32'hAA22CC44});
    vecs.push_back(vec_t'{2'd0, 1'b0, 1'b1, 4'h0, 4'd4,  32'h55555555, 32'hAA22CC44});
    vecs.push_back(vec_t'{2'd0, 1'b0, 1'b0, 4'h0, 4'd4,  32'h0,        32'hAA22CC44});
    vecs.push_back(vec_t'{2'd1, 1'b0, 1'b1, 4'hF, 4'd4,  32'hAABBCCDD, 32'h00000000});
    vecs.push_back(vec_t'{2'd1, 1'b0, 1'b1, 4'h5, 4'd4,  32'h11223344, 32'hAABBCCDD});
    vecs.push_back(vec_t'{2'd1, 1'b1, 1'b0, 4'h0, 4'd4,  32'h0,        32'hAA22CC44});
    vecs.push_back(vec_t'{2'd2, 1'b0, 1'b1, 4'hF, 4'd2,  32'hCAFEF00D, 32'h00000000});
    vecs.push_back(vec_t'{2'd2, 1'b0, 1'b0, 4'h0, 4'd2,  32'h0,        32'hCAFEF00D});
    vecs.push_back(vec_t'{2'd2, 1'b0, 1'b1, 4'hF, 4'd2,  32'h12345678, 32'hCAFEF00D});
    vecs.push_back(vec_t'{2'd2, 1'b0, 1'b0, 4'h0, 4'd2,  32'h0,        32'h12345678});
    vecs.push_back(vec_t'{2'd3, 1'b0, 1'b1, 4'hF, 4'd1,  32'h01010101, 32'h00000000});
    vecs.push_back(vec_t'{2'd3, 1'b0, 1'b0, 4'h0, 4'd1,  32'h0,        32'h01010101});
    vecs.push_back(vec_t'{2'd3, 1'b0, 1'b1, 4'hF, 4'd13, 32'hFFFFFFFF, 32'h00000000});
    vecs.push_back(vec_t'{2'd3, 1'b0, 1'b0, 4'h0, 4'd1,  32'h0,        32'h01010101});
    vecs.push_back(vec_t'{2'd3, 1'b0, 1'b0, 4'h0, 4'd13, 32'h0,        32'h00000000});
    vecs.push_back(vec_t'{2'd3, 1'b0, 1'b1, 4'hF, 4'd11, 32'hABCDEF01, 32'h00000000});
    vecs.push_back(vec_t'{2'd3, 1'b0, 1'b0, 4'h0, 4'd11, 32'h0,        32'hABCDEF01});

    sel = 2'd0;
    reset = 1'b1;
    a_req_valid = 1'b0; a_we = 1'b0; a_be = '0; a_addr = '0; a_wdata = '0; a_rsp_ready = 1'b1;
    b_req_valid = 1'b0; b_we = 1'b0; b_be = '0; b_addr = '0; b_wdata = '0; b_rsp_ready = 1'b1;

    // Reset state of every configuration.
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      check("rst_a_req_ready", 32'(a_ready_v[k]), 32'd0);
      check("rst_b_req_ready", 32'(b_ready_v[k]), 32'd0);
      check("rst_a_rsp_valid", 32'(a_valid_v[k]), 32'd0);
      check("rst_a_rdata",     a_rdata_v[k],      32'd0);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      check("post_rst_a_ready", 32'(a_ready_v[k]), 32'd1);
      check("post_rst_b_ready", 32'(b_ready_v[k]), 32'd1);
    end
    @(posedge clk);
    #1;

    // Cross-port collisions on the WRITE_FIRST instance.
    sel = 2'd0;
    issue(1'b0, 1'b1, 4'hF, 4'd5, 32'hFF123456, 32'hFF123456);
    dual(1'b1, 4'h3, 4'd5, 32'h000000FF, 32'hFF1200FF,
         1'b1, 4'h6, 4'd5, 32'hFFFF0000, 32'hFFFF0056);
    issue(1'b0, 1'b0, 4'h0, 4'd5, 32'h0, 32'hFFFF00FF);
    dual(1'b0, 4'h0, 4'd5, 32'h0, 32'hFFFF00FF,
         1'b1, 4'hF, 4'd5, 32'h12345678, 32'h12345678);
    issue(1'b1, 1'b0, 4'h0, 4'd5, 32'h0, 32'h12345678);
    drain();

    // Table-driven vectors, back-to-back within each configuration.
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].dut != sel) begin
        drain();
        sel = vecs[i].dut;
      end
      issue(vecs[i].port, vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].wdata, vecs[i].exp);
    end
    drain();

    // OUT_REG=1 instance: preload, then 8 reads under toggling back-pressure.
    sel = 2'd2;
    for (int i = 0; i < 8; i++) issue(1'b0, 1'b1, 4'hF, 4'(i), 32'hB0B00000 + i, 32'h12345678);
    issue(1'b0, 1'b1, 4'hF, 4'd9, 32'h99999999, 32'h12345678);
    drain();
    bp_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) issue(1'b0, 1'b0, 4'h0, 4'(i), 32'h0, 32'hB0B00000 + i);
        bp_done = 1'b1;
      end
      begin
        idx = 0;
        while (!bp_done) begin
          @(posedge clk);
          #1;
          a_rsp_ready = ((idx % 4) == 0) || ((idx % 4) == 3);
          idx++;
        end
      end
    join
    a_rsp_ready = 1'b1;
    drain();

    // Full stall: two accepts fill S1/S2, then reset drops both in-flight beats.
    a_rsp_ready = 1'b0;
    a_req_valid = 1'b1; a_we = 1'b0; a_be = '0; a_addr = 4'd9;
    acc = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (a_req_ready) acc++;
      @(posedge clk);
      #1;
    end
    check("stall_accepts", 32'(acc), 32'd2);
    @(negedge clk);
    check("stall_req_ready", 32'(a_req_ready), 32'd0);
    check("stall_rsp_valid", 32'(a_rsp_valid), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    a_we = 1'b1; a_be = 4'hF; a_wdata = 32'h0; a_rsp_ready = 1'b1;
    @(negedge clk);
    check("rst_cycle_req_ready", 32'(a_req_ready), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    a_req_valid = 1'b0;
    a_we = 1'b0;
    @(negedge clk);
    check("after_rst_rsp_valid", 32'(a_rsp_valid), 32'd0);
    check("after_rst_rdata", a_rdata, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    issue(1'b0, 1'b0, 4'h0, 4'd9, 32'h0, 32'h99999999);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
